// File: rtl/node_packet_injector.sv
`timescale 1ns/1ps
// Bridge from a clocked valid/ready producer to an asynchronous NoC node dg port.
// Packets are queued in a small FIFO and handed over with a 4-phase bundled-data handshake.
module node_packet_injector #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_req,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ack,
    output logic [15:0]              sent_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_REQ_HI = 2'd2,
        ST_ACK_HI = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   ack_s;
    logic [WIDTH-1:0]       mem_r [DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [LW-1:0]          level_r;
    logic [LW-1:0]          level_nxt_s;
    logic                   in_ready_r;
    logic                   push_s;
    logic                   pop_s;
    logic                   done_s;
    logic                   out_req_r;
    logic [WIDTH-1:0]       out_data_r;
    logic [15:0]            sent_count_r;

    assign push_s     = in_valid & in_ready_r;
    assign ack_s      = sync_r[SYNC_STAGES-1];
    assign in_ready   = in_ready_r;
    assign out_req    = out_req_r;
    assign out_data   = out_data_r;
    assign sent_count = sent_count_r;
    assign fifo_level = level_r;

    // Ack synchronizer: the node's acknowledge is asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], out_ack};
        end
    end

    // Handshake FSM next-state; a pop happens only when leaving IDLE with no stale ack.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((level_r != {LW{1'b0}}) && !ack_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_REQ_HI;
            end
            ST_REQ_HI: begin
                if (ack_s) begin
                    state_nxt_s = ST_ACK_HI;
                end else begin
                    state_nxt_s = ST_REQ_HI;
                end
            end
            ST_ACK_HI: begin
                if (!ack_s) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACK_HI;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FIFO occupancy next value; simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_nxt_s = level_r;
        if (push_s && !pop_s) begin
            level_nxt_s = level_r + LVL_ONE;
        end else if (!push_s && pop_s) begin
            level_nxt_s = level_r - LVL_ONE;
        end else begin
            level_nxt_s = level_r;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {LW{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r    <= level_nxt_s;
            in_ready_r <= (level_nxt_s != LVL_FULL);
        end
    end

    // FSM state and handshake outputs; out_data only loads on a pop, so it is
    // stable through SETUP, REQ_HI and ACK_HI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            out_req_r    <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
            sent_count_r <= 16'h0000;
        end else begin
            state_r   <= state_nxt_s;
            out_req_r <= (state_nxt_s == ST_REQ_HI);
            if (pop_s) begin
                out_data_r <= mem_r[rd_ptr_r];
            end
            if (done_s) begin
                sent_count_r <= sent_count_r + 16'h0001;
            end
        end
    end

endmodule
